// File: rtl/gtp_tx_sched.sv
// gtp_tx_sched: round-robin GTP TX frame scheduler (SOF/ID/HEAD/DATA/CRC/EOF) with trigger-frame insertion.
// Optional source-stall watchdog with zero padding: define GTP_TX_TIMEOUT_EN.
module gtp_tx_sched #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  log_clk,
  input  logic                  log_rst_q,
  input  logic [31:0]           gtx_id,
  input  logic                  trig_req,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [8*NUM_REQ-1:0]  req_len,
  input  logic [8*NUM_REQ-1:0]  req_head,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [NUM_REQ-1:0]    done,
  input  logic [32*NUM_REQ-1:0] src_tdata,
  input  logic [NUM_REQ-1:0]    src_tvalid,
  output logic [NUM_REQ-1:0]    src_tready,
  output logic [31:0]           tx_tdata,
  output logic                  tx_tvalid,
  output logic                  tx_tlast,
  input  logic                  tx_tready,
  output logic                  trig_drop,
  output logic                  tx_err
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic [2:0] {IDLE, TRIG, SOF, ID, HEAD, DATA, CRC, EOF} state_t;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("gtp_tx_sched: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  // MSB-first CRC-32, 32 data bits per step, no reflection
  function automatic logic [31:0] crc32_d32(input logic [31:0] d, input logic [31:0] c);
    logic [31:0] r;
    r = c;
    for (int i = 31; i >= 0; i--) r = {r[30:0], 1'b0} ^ ((r[31] ^ d[i]) ? 32'h04C11DB7 : 32'h0);
    return r;
  endfunction

  state_t         state;
  logic [IW-1:0]  g, ptr, sel;
  logic [7:0]     len, head, cnt;
  logic [31:0]    id_q, crc, src_d, dword;
  logic           trig_pend, src_v, xfer, acc_trig;

  always_comb begin
    sel = ptr;
    for (int k = NUM_REQ; k >= 1; k--) sel = req[(int'(ptr) + k) % NUM_REQ] ? IW'((int'(ptr) + k) % NUM_REQ) : sel;
  end

`ifdef GTP_TX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_cnt;
  logic          pad, err;
  always_ff @(posedge log_clk or posedge log_rst_q) begin
    if (log_rst_q) begin
      idle_cnt <= '0;
      pad      <= 1'b0;
      err      <= 1'b0;
    end else if (state != DATA) begin
      idle_cnt <= '0;
      pad      <= 1'b0;
    end else if (!pad) begin
      idle_cnt <= src_v ? '0 : idle_cnt + 1'b1;
      if (!src_v && idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
        pad <= 1'b1;
        err <= 1'b1;
      end
    end
  end
  assign tx_err = err;
`else
  logic pad;
  assign pad    = 1'b0;
  assign tx_err = 1'b0;
`endif

  assign src_v    = src_tvalid[g];
  assign src_d    = src_tdata[32*g +: 32];
  assign dword    = pad ? 32'h0 : src_d;
  assign xfer     = tx_tvalid && tx_tready;
  assign acc_trig = (state == TRIG) && xfer;

  // stream outputs decode straight from state so reset kills tvalid without waiting for a clock
  always_comb begin
    tx_tvalid  = (state == DATA) ? (pad || src_v) : (state != IDLE);
    tx_tlast   = (state == TRIG) || (state == EOF);
    tx_tdata   = (state == TRIG) ? 32'h0000FFBA :
                 (state == SOF)  ? 32'h0000FFBC :
                 (state == ID)   ? id_q :
                 (state == HEAD) ? {16'h0, head, len} :
                 (state == DATA) ? dword :
                 (state == CRC)  ? crc :
                 (state == EOF)  ? 32'h0000FFBD : 32'h0;
    src_tready = (state == DATA && !pad && tx_tready) ? NUM_REQ'(1) << g : '0;
  end

  always_ff @(posedge log_clk or posedge log_rst_q) begin
    if (log_rst_q) begin
      state     <= IDLE;
      g         <= '0;
      ptr       <= IW'(NUM_REQ - 1);
      len       <= '0;
      head      <= '0;
      cnt       <= '0;
      id_q      <= '0;
      crc       <= 32'hFFFFFFFF;
      trig_pend <= 1'b0;
      trig_drop <= 1'b0;
      gnt       <= '0;
      done      <= '0;
    end else begin
      done      <= '0;
      trig_drop <= trig_req && trig_pend && !acc_trig;
      trig_pend <= trig_req || (trig_pend && !acc_trig);
      case (state)
        IDLE: if (trig_pend) state <= TRIG;
              else if (|req) begin
                g     <= sel;
                ptr   <= sel;
                len   <= req_len[8*sel +: 8];
                head  <= req_head[8*sel +: 8];
                gnt   <= NUM_REQ'(1) << sel;
                state <= SOF;
              end
        TRIG: if (xfer) state <= IDLE;
        SOF:  if (xfer) begin
                id_q  <= gtx_id;
                state <= ID;
              end
        ID:   if (xfer) begin
                crc   <= crc32_d32(id_q, crc);
                state <= HEAD;
              end
        HEAD: if (xfer) begin
                crc   <= crc32_d32({16'h0, head, len}, crc);
                cnt   <= '0;
                state <= (len == 8'd0) ? CRC : DATA;
              end
        DATA: if (xfer) begin
                crc <= crc32_d32(dword, crc);
                cnt <= cnt + 8'd1;
                if (cnt + 8'd1 == len) state <= CRC;
              end
        CRC:  if (xfer) state <= EOF;
        EOF:  if (xfer) begin
                done  <= gnt;
                gnt   <= '0;
                crc   <= 32'hFFFFFFFF;
                state <= IDLE;
              end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gtp_tx_sched.sv
// tb_gtp_tx_sched: randomized self-checking bench for gtp_tx_sched against a frame-level reference model.
module tb_gtp_tx_sched;
  localparam int N = 4;

  logic            log_clk = 1'b0, log_rst_q = 1'b1;
  logic [31:0]     gtx_id = '0;
  logic            trig_req = 1'b0;
  logic [N-1:0]    req = '0;
  logic [8*N-1:0]  req_len = '0, req_head = '0;
  logic [N-1:0]    gnt, done, src_tready;
  logic [32*N-1:0] src_tdata = '0;
  logic [N-1:0]    src_tvalid = '0;
  logic [31:0]     tx_tdata;
  logic            tx_tvalid, tx_tlast, trig_drop, tx_err;
  logic            tx_tready = 1'b1;

  always #5 log_clk = ~log_clk;

  gtp_tx_sched #(.NUM_REQ(N), .TIMEOUT_CYCLES(16)) dut (
    .log_clk(log_clk), .log_rst_q(log_rst_q), .gtx_id(gtx_id), .trig_req(trig_req),
    .req(req), .req_len(req_len), .req_head(req_head), .gnt(gnt), .done(done),
    .src_tdata(src_tdata), .src_tvalid(src_tvalid), .src_tready(src_tready),
    .tx_tdata(tx_tdata), .tx_tvalid(tx_tvalid), .tx_tlast(tx_tlast), .tx_tready(tx_tready),
    .trig_drop(trig_drop), .tx_err(tx_err)
  );

  typedef struct packed {logic last; logic [N-1:0] g; logic [31:0] d;} rec_t;
  rec_t         txq[$];
  logic [32:0]  expq[$];
  logic [N-1:0] expg[$];
  logic [31:0]  sq[N][$];
  logic [31:0]  mq[N][$];
  int           n_chk, n_pass, drop_cnt, stall_bad, sof_n;
  int           done_cnt[N];
  bit           rand_rdy, gap_en, hold_req, trig_fire, rdy_seen, prev_stall;
  logic [31:0]  prev_d;
  logic         prev_l;

  // byte-table style CRC-32 (poly 04C11DB7, MSB first, no reflection, no final xor)
  function automatic logic [31:0] crc_word(input logic [31:0] c, input logic [31:0] w);
    logic [31:0] t;
    for (int b = 3; b >= 0; b--) begin
      t = {c[31:24] ^ w[8*b +: 8], 24'h0};
      repeat (8) t = t[31] ? ((t << 1) ^ 32'h04C11DB7) : (t << 1);
      c = (c << 8) ^ t;
    end
    return c;
  endfunction

  task automatic push_frame(input int i, input logic [7:0] l, input logic [7:0] h, input logic [31:0] id);
    logic [31:0] c, w;
    c = 32'hFFFFFFFF;
    expq.push_back({1'b0, 32'h0000FFBC});
    expq.push_back({1'b0, id});
    c = crc_word(c, id);
    w = {16'h0, h, l};
    expq.push_back({1'b0, w});
    c = crc_word(c, w);
    for (int k = 0; k < int'(l); k++) begin
      w = 32'h0;
      if (mq[i].size() > 0) w = mq[i].pop_front();
      expq.push_back({1'b0, w});
      c = crc_word(c, w);
    end
    expq.push_back({1'b0, c});
    expq.push_back({1'b1, 32'h0000FFBD});
    expg.push_back(N'(1) << i);
  endtask

  task automatic load(input int i, input int n);
    logic [31:0] w;
    repeat (n) begin
      w = $urandom;
      sq[i].push_back(w);
      mq[i].push_back(w);
    end
  endtask

  task automatic setup(input int i, input logic [7:0] l, input logic [7:0] h);
    req_len[8*i +: 8]  = l;
    req_head[8*i +: 8] = h;
  endtask

  task automatic tick();
    bit [N-1:0] acc;
    acc = '0;
    @(negedge log_clk);
    if (prev_stall && (!tx_tvalid || tx_tdata !== prev_d || tx_tlast !== prev_l)) stall_bad++;
    prev_stall = tx_tvalid && !tx_tready;
    prev_d = tx_tdata;
    prev_l = tx_tlast;
    if (tx_tvalid && tx_tready) begin
      txq.push_back('{tx_tlast, gnt, tx_tdata});
      if (tx_tdata == 32'h0000FFBC && !tx_tlast) sof_n++;
    end
    for (int i = 0; i < N; i++) begin
      if (src_tvalid[i] && src_tready[i]) begin
        void'(sq[i].pop_front());
        acc[i] = 1'b1;
      end
      done_cnt[i] += int'(done[i]);
    end
    if (|src_tready) rdy_seen = 1'b1;
    if (trig_drop) drop_cnt++;
    @(posedge log_clk);
    #1;
    trig_req  = trig_fire;
    trig_fire = 1'b0;
    if (!hold_req) req = req & ~gnt;
    for (int i = 0; i < N; i++) begin
      if (!(src_tvalid[i] && !acc[i])) begin
        if (sq[i].size() > 0 && (!gap_en || $urandom_range(3) != 0)) begin
          src_tvalid[i] = 1'b1;
          src_tdata[32*i +: 32] = sq[i][0];
        end else src_tvalid[i] = 1'b0;
      end
    end
    tx_tready = rand_rdy ? 1'($urandom_range(1)) : 1'b1;
  endtask

  task automatic run(input int budget);
    int c;
    c = 0;
    while (txq.size() < expq.size() && c < budget) begin
      tick();
      c++;
    end
    repeat (3) tick();
  endtask

  task automatic do_reset();
    log_rst_q = 1'b1;
    req = '0; src_tvalid = '0; src_tdata = '0; trig_req = 1'b0; tx_tready = 1'b1;
    trig_fire = 0; rand_rdy = 0; gap_en = 0; hold_req = 0; prev_stall = 0; rdy_seen = 0;
    txq.delete(); expq.delete(); expg.delete();
    for (int i = 0; i < N; i++) begin
      sq[i].delete();
      mq[i].delete();
      done_cnt[i] = 0;
    end
    drop_cnt = 0; stall_bad = 0; sof_n = 0;
    repeat (2) @(posedge log_clk);
    #1 log_rst_q = 1'b0;
  endtask

  task automatic test_reset();
    log_rst_q = 1'b1;
    repeat (2) @(posedge log_clk);
    #1;
    n_chk++; if (tx_tvalid !== 1'b0) $display("FAIL reset_tvalid got %b want 0", tx_tvalid); else n_pass++;
    n_chk++; if (tx_tlast !== 1'b0) $display("FAIL reset_tlast got %b want 0", tx_tlast); else n_pass++;
    n_chk++; if (tx_tdata !== 32'h0) $display("FAIL reset_tdata got %h want 0", tx_tdata); else n_pass++;
    n_chk++; if (gnt !== '0) $display("FAIL reset_gnt got %b want 0", gnt); else n_pass++;
    n_chk++; if (done !== '0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
    n_chk++; if (src_tready !== '0) $display("FAIL reset_src_tready got %b want 0", src_tready); else n_pass++;
    n_chk++; if (trig_drop !== 1'b0) $display("FAIL reset_trig_drop got %b want 0", trig_drop); else n_pass++;
    n_chk++; if (tx_err !== 1'b0) $display("FAIL reset_tx_err got %b want 0", tx_err); else n_pass++;
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    gtx_id = 32'h12345678;
    setup(1, 8'd3, 8'h10);
    load(1, 3);
    push_frame(1, 8'd3, 8'h10, gtx_id);
    req[1] = 1'b1;
    run(100);
    n_chk++; if (txq.size() != expq.size()) $display("FAIL single_len got %0d want %0d", txq.size(), expq.size()); else n_pass++;
    for (int k = 0; k < txq.size() && k < expq.size(); k++) begin
      n_chk++; if ({txq[k].last, txq[k].d} !== expq[k]) $display("FAIL single_word[%0d] got %h want %h", k, {txq[k].last, txq[k].d}, expq[k]); else n_pass++;
    end
    if (txq.size() > 2) begin
      n_chk++; if (txq[2].d !== 32'h00001003) $display("FAIL single_head got %h want 00001003", txq[2].d); else n_pass++;
      n_chk++; if (txq[0].g !== 4'b0010) $display("FAIL single_gnt got %b want 0010", txq[0].g); else n_pass++;
    end
    n_chk++; if (done_cnt[1] != 1) $display("FAIL single_done got %0d cycles want 1", done_cnt[1]); else n_pass++;
    n_chk++; if (done_cnt[0] + done_cnt[2] + done_cnt[3] != 0) $display("FAIL single_done_other got %0d want 0", done_cnt[0] + done_cnt[2] + done_cnt[3]); else n_pass++;
  endtask

  task automatic test_rr();
    int last, nx, c, j;
    do_reset();
    gtx_id = $urandom;
    for (int i = 0; i < N; i++) setup(i, 8'd1, 8'h00);
    load(0, 2);
    for (int i = 1; i < N; i++) load(i, 1);
    last = N - 1;
    for (int f = 0; f < 5; f++) begin
      nx = (last + 1) % N;
      push_frame(nx, 8'd1, 8'h00, gtx_id);
      last = nx;
    end
    hold_req = 1'b1;
    req = '1;
    c = 0;
    while (sof_n < 5 && c < 300) begin
      tick();
      c++;
    end
    req = '0;
    hold_req = 1'b0;
    run(300);
    n_chk++; if (txq.size() != expq.size()) $display("FAIL rr_len got %0d want %0d", txq.size(), expq.size()); else n_pass++;
    for (int k = 0; k < txq.size() && k < expq.size(); k++) begin
      n_chk++; if ({txq[k].last, txq[k].d} !== expq[k]) $display("FAIL rr_word[%0d] got %h want %h", k, {txq[k].last, txq[k].d}, expq[k]); else n_pass++;
    end
    j = 0;
    for (int k = 0; k < txq.size(); k++) begin
      if (txq[k].d === 32'h0000FFBC && j < expg.size()) begin
        n_chk++; if (txq[k].g !== expg[j]) $display("FAIL rr_gnt[%0d] got %b want %b", j, txq[k].g, expg[j]); else n_pass++;
        j++;
      end
    end
  endtask

  task automatic test_trigger();
    int c;
    do_reset();
    gtx_id = $urandom;
    setup(2, 8'd4, 8'h22);
    setup(0, 8'd2, 8'h33);
    load(2, 4);
    load(0, 2);
    push_frame(2, 8'd4, 8'h22, gtx_id);
    expq.push_back({1'b1, 32'h0000FFBA});
    push_frame(0, 8'd2, 8'h33, gtx_id);
    req[2] = 1'b1;
    c = 0;
    while (txq.size() < 3 && c < 50) begin
      tick();
      c++;
    end
    trig_fire = 1'b1;
    tick();
    tick();
    trig_fire = 1'b1;
    req[0] = 1'b1;
    run(300);
    n_chk++; if (txq.size() != expq.size()) $display("FAIL trig_len got %0d want %0d", txq.size(), expq.size()); else n_pass++;
    for (int k = 0; k < txq.size() && k < expq.size(); k++) begin
      n_chk++; if ({txq[k].last, txq[k].d} !== expq[k]) $display("FAIL trig_word[%0d] got %h want %h", k, {txq[k].last, txq[k].d}, expq[k]); else n_pass++;
    end
    n_chk++; if (drop_cnt != 1) $display("FAIL trig_drop got %0d pulses want 1", drop_cnt); else n_pass++;
  endtask

  task automatic test_len0();
    do_reset();
    gtx_id = $urandom;
    setup(1, 8'd0, 8'h44);
    push_frame(1, 8'd0, 8'h44, gtx_id);
    req[1] = 1'b1;
    run(100);
    n_chk++; if (txq.size() != expq.size()) $display("FAIL len0_len got %0d want %0d", txq.size(), expq.size()); else n_pass++;
    for (int k = 0; k < txq.size() && k < expq.size(); k++) begin
      n_chk++; if ({txq[k].last, txq[k].d} !== expq[k]) $display("FAIL len0_word[%0d] got %h want %h", k, {txq[k].last, txq[k].d}, expq[k]); else n_pass++;
    end
    n_chk++; if (rdy_seen !== 1'b0) $display("FAIL len0_src_tready got %b want 0", rdy_seen); else n_pass++;
    n_chk++; if (done_cnt[1] != 1) $display("FAIL len0_done got %0d want 1", done_cnt[1]); else n_pass++;
  endtask

  task automatic test_stall();
    int c;
    logic [7:0] h;
    do_reset();
    rand_rdy = 1'b1;
    gap_en = 1'b1;
    h = 8'($urandom);
    gtx_id = $urandom;
    setup(3, 8'd8, h);
    load(3, 8);
    push_frame(3, 8'd8, h, gtx_id);
    req[3] = 1'b1;
    c = 0;
    while (txq.size() < 1 && c < 50) begin
      tick();
      c++;
    end
    req_len[31:24] = 8'hFF;
    run(400);
    n_chk++; if (txq.size() != expq.size()) $display("FAIL stall_len got %0d want %0d", txq.size(), expq.size()); else n_pass++;
    for (int k = 0; k < txq.size() && k < expq.size(); k++) begin
      n_chk++; if ({txq[k].last, txq[k].d} !== expq[k]) $display("FAIL stall_word[%0d] got %h want %h", k, {txq[k].last, txq[k].d}, expq[k]); else n_pass++;
    end
    n_chk++; if (stall_bad != 0) $display("FAIL stall_stable got %0d unstable stalls want 0", stall_bad); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int c;
    logic [7:0] h;
    do_reset();
    gtx_id = $urandom;
    setup(1, 8'd8, 8'h05);
    load(1, 3);
    req[1] = 1'b1;
    c = 0;
    while (txq.size() < 5 && c < 100) begin
      tick();
      c++;
    end
    #2 log_rst_q = 1'b1;
    #1;
    n_chk++; if (tx_tvalid !== 1'b0) $display("FAIL rstmid_tvalid got %b want 0", tx_tvalid); else n_pass++;
    n_chk++; if (gnt !== '0) $display("FAIL rstmid_gnt got %b want 0", gnt); else n_pass++;
    n_chk++; if (src_tready !== '0) $display("FAIL rstmid_src_tready got %b want 0", src_tready); else n_pass++;
    do_reset();
    h = 8'($urandom);
    gtx_id = $urandom;
    setup(1, 8'd2, h);
    load(1, 2);
    push_frame(1, 8'd2, h, gtx_id);
    req[1] = 1'b1;
    run(100);
    n_chk++; if (txq.size() != expq.size()) $display("FAIL rstmid_len got %0d want %0d", txq.size(), expq.size()); else n_pass++;
    for (int k = 0; k < txq.size() && k < expq.size(); k++) begin
      n_chk++; if ({txq[k].last, txq[k].d} !== expq[k]) $display("FAIL rstmid_word[%0d] got %h want %h", k, {txq[k].last, txq[k].d}, expq[k]); else n_pass++;
    end
  endtask

  task automatic test_random();
    int i;
    logic [7:0] l, h;
    do_reset();
    rand_rdy = 1'b1;
    gap_en = 1'b1;
    for (int f = 0; f < 6; f++) begin
      i = $urandom_range(N - 1);
      l = 8'($urandom_range(12));
      h = 8'($urandom);
      gtx_id = $urandom;
      setup(i, l, h);
      load(i, int'(l));
      push_frame(i, l, h, gtx_id);
      req[i] = 1'b1;
      run(400);
    end
    n_chk++; if (txq.size() != expq.size()) $display("FAIL rand_len got %0d want %0d", txq.size(), expq.size()); else n_pass++;
    for (int k = 0; k < txq.size() && k < expq.size(); k++) begin
      n_chk++; if ({txq[k].last, txq[k].d} !== expq[k]) $display("FAIL rand_word[%0d] got %h want %h", k, {txq[k].last, txq[k].d}, expq[k]); else n_pass++;
    end
    n_chk++; if (done_cnt[0] + done_cnt[1] + done_cnt[2] + done_cnt[3] != 6) $display("FAIL rand_done got %0d want 6", done_cnt[0] + done_cnt[1] + done_cnt[2] + done_cnt[3]); else n_pass++;
    n_chk++; if (stall_bad != 0) $display("FAIL rand_stable got %0d want 0", stall_bad); else n_pass++;
`ifndef GTP_TX_TIMEOUT_EN
    n_chk++; if (tx_err !== 1'b0) $display("FAIL rand_tx_err got %b want 0", tx_err); else n_pass++;
`endif
  endtask

`ifdef GTP_TX_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    gtx_id = $urandom;
    setup(0, 8'd4, 8'h66);
    load(0, 2);
    push_frame(0, 8'd4, 8'h66, gtx_id);
    req[0] = 1'b1;
    run(200);
    n_chk++; if (txq.size() != expq.size()) $display("FAIL tmo_len got %0d want %0d", txq.size(), expq.size()); else n_pass++;
    for (int k = 0; k < txq.size() && k < expq.size(); k++) begin
      n_chk++; if ({txq[k].last, txq[k].d} !== expq[k]) $display("FAIL tmo_word[%0d] got %h want %h", k, {txq[k].last, txq[k].d}, expq[k]); else n_pass++;
    end
    n_chk++; if (tx_err !== 1'b1) $display("FAIL tmo_tx_err got %b want 1", tx_err); else n_pass++;
    n_chk++; if (done_cnt[0] != 1) $display("FAIL tmo_done got %0d want 1", done_cnt[0]); else n_pass++;
  endtask
`endif

  initial begin
    n_chk = 0;
    n_pass = 0;
    test_reset();
    test_single();
    test_rr();
    test_trigger();
    test_len0();
    test_stall();
    test_reset_mid();
    test_random();
`ifdef GTP_TX_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/gtp_tx_sched.md
Name: gtp_tx_sched

Overview:
- Transmit-side scheduler sharing one Aurora/GTP TX AXI-stream lane between NUM_REQ packet requesters and one trigger source.
- Arbitrates round-robin among the packet requesters.
- Wraps each granted payload in the link frame format: SOF 0xFFBC, GTX ID, head word, data words, CRC32, EOF 0xFFBD.
- Inserts single-word trigger frames (0xFFBA) between packets. Sits between the packet producers and the TX user interface, as the mirror of the RX frame decoder.

Parameters:
- NUM_REQ, 4, number of packet requesters (2..8).
- TIMEOUT_CYCLES, 1024, source-stall watchdog limit; used only with GTP_TX_TIMEOUT_EN.

Ports:
- log_clk  in  1  user clock for all logic.
- log_rst_q  in  1  reset, asynchronous, active-high.
- gtx_id  in  32  ID word placed after SOF; sampled at the SOF word.
- trig_req  in  1  single-cycle pulse requesting a trigger frame.
- req  in  NUM_REQ  per-requester packet request; level, held until gnt.
- req_len  in  8*NUM_REQ  payload word count per requester (slice i = [8i+7:8i]).
- req_head  in  8*NUM_REQ  destination start address per requester.
- gnt  out  NUM_REQ  one-hot grant, high from SOF accept until EOF accept.
- done  out  NUM_REQ  one-cycle pulse on EOF accept for the granted requester.
- src_tdata  in  32*NUM_REQ  payload data per requester.
- src_tvalid  in  NUM_REQ  payload valid per requester.
- src_tready  out  NUM_REQ  payload ready; only the granted slice can be 1.
- tx_tdata  out  32  TX stream data.
- tx_tvalid  out  1  TX stream valid.
- tx_tlast  out  1  TX stream last (EOF word or trigger word).
- tx_tready  in  1  TX stream ready from core.
- trig_drop  out  1  pulse when trig_req arrives while a trigger is already pending.
- tx_err  out  1  sticky timeout error; exists only with GTP_TX_TIMEOUT_EN, otherwise tied 0.

Behaviour:
- Reset values: all outputs 0; crc = 32'hFFFFFFFF; rr pointer = NUM_REQ-1; trig_pend = 0; state IDLE. Reset mid-frame aborts immediately. tvalid drops asynchronously and no EOF is sent.
- Transfers: a word is transferred when tx_tvalid && tx_tready. While tvalid=1 and tready=0, tdata, tlast and tvalid hold stable (AXI rule).
- Trigger pending: trig_pend is set by trig_req and cleared when the trigger word is accepted. trig_req while trig_pend=1 gives a trig_drop pulse on the next cycle; there is no counting. trig_req in the same cycle as the trigger-word accept sets trig_pend again, with no drop.
- IDLE: if trig_pend, go to TRIG (trigger has priority over packets). Otherwise, if any req, grant the first set bit searching from ptr+1 with wrap-around, latch len/head/index, set ptr=index, go to SOF. No word is driven in IDLE. Grant-to-first-word latency is 1 cycle.
- TRIG: drive 0xFFBA with tlast=1; on accept go to IDLE.
- SOF: drive 0x0000FFBC; on accept, latch gtx_id and go to ID.
- ID: drive the latched gtx_id; crc <= nextCRC32_D32(gtx_id, crc); on accept go to HEAD.
- HEAD: drive {16'h0, head, len}; CRC update; on accept go to DATA, or to CRC if len==0.
- DATA: src_tready[g] = tx_tready; tx_tvalid = src_tvalid[g]; tdata = src slice g. CRC updates and an 8-bit word counter increments on each transfer. On transfer number len, go to CRC.
- CRC: drive crc (no final inversion, no reflection); on accept go to EOF.
- EOF: drive 0x0000FFBD with tlast=1; on accept, pulse done[g], clear gnt, reset crc to FFFFFFFF, go to IDLE.
- CRC function: CRC-32 (poly 0x04C11DB7), 32-bit parallel update, same equations the RX checker uses. The CRC covers the ID, HEAD and DATA words only.
- gnt[g] is held throughout SOF..EOF. Deassertion of req[g] mid-frame is ignored and the frame completes.
- A trigger arriving mid-frame waits until after EOF. It is never inserted inside a packet.
- req_len is latched at grant; later changes are ignored until the next grant.

Optional Feature:
- Macro: GTP_TX_TIMEOUT_EN.
- With the macro: in DATA, a counter counts consecutive cycles with src_tvalid[g]=0. When it reaches TIMEOUT_CYCLES, the block forces src_tready[g]=0 and pads the remaining words with 32'h0 (included in the CRC). It then sends CRC and EOF normally, sets tx_err sticky until reset, and still pulses done.
- Without the macro: DATA waits indefinitely; tx_err is constant 0 and no counter is built.

Test Plan:
- Reset, then req[1]=1, len=3, head=0x10, gtx_id=0x12345678, tready=1 -> tx words FFBC, 12345678, 00001003, d0, d1, d2, CRC, FFBD with tlast on FFBD only. done[1] is one pulse. CRC matches the software model, and a loopback into the RX decoder gives gtp_rx_done=1.
- req=4'b1111 held, len=1 each -> grant order 0,1,2,3,0; no requester is granted twice in a row while others wait.
- trig_req mid-frame of requester 2 -> frame completes unbroken, then FFBA with tlast appears next, before any further packet SOF. A second trig_req before that gives one trig_drop pulse.
- tready toggled 1/0 randomly, src_tvalid gapped, len=8 -> output word sequence identical to the tready=1 case, and data is stable while stalled.
- len=0 -> FFBC, ID, HEAD, CRC, FFBD; src_tready never asserted. Assert log_rst_q during DATA -> tvalid and gnt are 0 immediately, and after release the next frame starts with crc=FFFFFFFF.
- With GTP_TX_TIMEOUT_EN and TIMEOUT_CYCLES=16: len=4, the source stops after 2 words -> after 16 idle cycles, 2 zero words, CRC and EOF are sent, tx_err=1 and done pulses.
